mp_add_sequencer: RTL and testbench

Multi-precision add/subtract controller that time-multiplexes a single N-bit ripple full-adder (`fulladderNb`) across WORDS operand words. It computes a WORDS*N-bit sum or difference one word per clock, least-significant word first, chaining the carry through a register. It sits between a requester issuing wide arithmetic operations and the shared N-bit adder datapath. It owns the adder instance, its operand muxing and the carry sequencing.

---
 rtl/mp_add_if.sv | 28 ++
 rtl/mp_add_sequencer.sv | 116 +++++++++++
 tb/tb_mp_add_sequencer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mp_add_if.sv
// Request/response bundle between a wide-arithmetic requester and mp_add_sequencer.
// The requester drives the operation fields; the sequencer returns status and the result.
interface mp_add_if #(
    parameter int N     = 16,
    parameter int WORDS = 4
);
    localparam int W = N * WORDS;

    logic         start;
    logic         sub;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;

    modport master (
        output start, sub, op_a, op_b,
        input  busy, done, result, cout, overflow
    );

    modport slave (
        input  start, sub, op_a, op_b,
        output busy, done, result, cout, overflow
    );
endinterface

// File: rtl/mp_add_sequencer.sv
// Multi-precision add/subtract: one shared N-bit adder is stepped across WORDS words,
// LSW first, with the inter-word carry held in a register.

module fulladderNb #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
endmodule

module mp_add_sequencer #(
    parameter int N     = 16,
    parameter int WORDS = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    mp_add_if.slave bus
);
    localparam int W  = N * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic          carry;
    logic          sub_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  res_q;
    logic          busy_q;
    logic          done_q;
    logic          cout_q;
    logic          ovf_q;

    logic [N-1:0]  a_w;
    logic [N-1:0]  b_w;
    logic [N-1:0]  sum_w;
    logic          co_w;

    // Subtraction is A + ~B + 1: B is inverted here and the +1 enters as the initial carry.
    always_comb begin
        a_w = a_q[N*int'(idx) +: N];
        b_w = b_q[N*int'(idx) +: N] ^ {N{sub_q}};
    end

    fulladderNb #(.N(N)) u_add (
        .a    (a_w),
        .b    (b_w),
        .cin  (carry),
        .sum  (sum_w),
        .cout (co_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            sub_q  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q    <= bus.op_a;
                        b_q    <= bus.op_b;
                        sub_q  <= bus.sub;
                        carry  <= bus.sub;
                        idx    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    res_q[N*int'(idx) +: N] <= sum_w;
                    carry                   <= co_w;
                    if (idx == LAST) begin
                        cout_q <= co_w;
                        ovf_q  <= (a_w[N-1] == b_w[N-1]) && (sum_w[N-1] != a_w[N-1]);
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = res_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_mp_add_sequencer.sv
// Bench for mp_add_sequencer (N=16, WORDS=4): directed corner vectors plus random
// operations checked against whole-width signed/unsigned arithmetic.
module tb_mp_add_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mp_add_if #(.N(16), .WORDS(4)) bus ();

    mp_add_sequencer #(.N(16), .WORDS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference: full 64-bit arithmetic, borrow and signed range taken directly.
    task automatic model(input logic [63:0] a, input logic [63:0] b, input logic s,
                         output logic [63:0] r, output logic c, output logic o);
        logic signed [64:0] sa, sb, t;
        logic [64:0] u;
        sa = $signed({a[63], a});
        sb = $signed({b[63], b});
        t  = s ? (sa - sb) : (sa + sb);
        u  = {1'b0, a} + {1'b0, b};
        r  = t[63:0];
        o  = (t[64] != t[63]);
        c  = s ? (a >= b) : u[64];
    endtask

    task automatic run_op(input string name, input logic [63:0] a, input logic [63:0] b,
                          input logic s, input logic [63:0] er, input logic ec, input logic eo);
        int n;
        @(negedge clk);
        bus.start = 1'b1; bus.op_a = a; bus.op_b = b; bus.sub = s;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.op_a  = {$urandom, $urandom};
        bus.op_b  = {$urandom, $urandom};
        bus.sub   = 1'($urandom);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL %s busy_after_start: got %b want 1", name, bus.busy);
        end
        n = 0;
        while (n < 20) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (bus.done === 1'b1) break;
        end
        checks++;
        if (n !== 4) begin
            errors++; $display("FAIL %s done_latency: got %0d want 4", name, n);
        end
        checks++;
        if (bus.result !== er) begin
            errors++; $display("FAIL %s result: got %h want %h", name, bus.result, er);
        end
        checks++;
        if (bus.cout !== ec) begin
            errors++; $display("FAIL %s cout: got %b want %b", name, bus.cout, ec);
        end
        checks++;
        if (bus.overflow !== eo) begin
            errors++; $display("FAIL %s overflow: got %b want %b", name, bus.overflow, eo);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== er) begin
            errors++;
            $display("FAIL %s after_done: busy %b done %b result %h want 0 0 %h",
                     name, bus.busy, bus.done, bus.result, er);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.start = 1'($urandom); bus.sub = 1'($urandom);
            bus.op_a = {$urandom, $urandom}; bus.op_b = {$urandom, $urandom};
        end
        checks++;
        if ({bus.busy, bus.done, bus.cout, bus.overflow} !== 4'b0 || bus.result !== 64'd0) begin
            errors++;
            $display("FAIL reset_hold: busy %b done %b cout %b ovf %b result %h want all 0",
                     bus.busy, bus.done, bus.cout, bus.overflow, bus.result);
        end
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.cout, bus.overflow} !== 4'b0 || bus.result !== 64'd0) begin
            errors++;
            $display("FAIL reset_release: busy %b done %b cout %b ovf %b result %h want all 0",
                     bus.busy, bus.done, bus.cout, bus.overflow, bus.result);
        end
    endtask

    task automatic test_directed();
        run_op("word_carry", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
        run_op("full_chain", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0);
        run_op("signed_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        run_op("sub_5_7", 64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        run_op("sub_7_5", 64'd7, 64'd5, 1'b1, 64'h2, 1'b1, 1'b0);
        run_op("sub_min_1", 64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        logic [63:0] a, b, r;
        logic s, c, o;
        for (int i = 0; i < 20; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (i % 5 == 0) b[63] = a[63];
            s = 1'($urandom);
            model(a, b, s, r, c, o);
            run_op("random", a, b, s, r, c, o);
        end
    endtask

    task automatic test_start_during_run();
        logic [63:0] r;
        logic c, o;
        int n;
        model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, r, c, o);
        @(negedge clk);
        bus.start = 1'b1; bus.sub = 1'b0;
        bus.op_a = 64'h1234_5678_9ABC_DEF0; bus.op_b = 64'h0FED_CBA9_8765_4321;
        @(posedge clk);
        @(negedge clk);
        bus.op_a = 64'hFFFF_0000_FFFF_0000; bus.op_b = 64'h0000_FFFF_0000_FFFF; bus.sub = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        n = 2;
        while (n < 20 && bus.done !== 1'b1) begin
            @(negedge clk); n++;
        end
        checks++;
        if (n !== 4) begin
            errors++; $display("FAIL restart_ignored latency: got %0d want 4", n);
        end
        checks++;
        if (bus.result !== r || bus.cout !== c) begin
            errors++; $display("FAIL restart_ignored result: got %h/%b want %h/%b", bus.result, bus.cout, r, c);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL restart_ignored idle: busy got %b want 0", bus.busy);
        end
    endtask

    task automatic test_start_held();
        int last, ndone;
        logic [63:0] a, b, r;
        logic c, o;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        model(a, b, 1'b1, r, c, o);
        last = -1; ndone = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.op_a = a; bus.op_b = b; bus.sub = 1'b1;
        for (int cyc = 0; cyc < 26; cyc++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                ndone++;
                checks++;
                if (bus.result !== r || bus.overflow !== o) begin
                    errors++; $display("FAIL held_start result: got %h/%b want %h/%b", bus.result, bus.overflow, r, o);
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last !== 6) begin
                        errors++; $display("FAIL held_start spacing: got %0d want 6", cyc - last);
                    end
                end
                last = cyc;
            end
        end
        bus.start = 1'b0;
        checks++;
        if (ndone < 4) begin
            errors++; $display("FAIL held_start count: got %0d want >= 4", ndone);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        bus.start = 1'b1; bus.sub = 1'b0;
        bus.op_a = 64'hFFFF_FFFF_FFFF_FFFF; bus.op_b = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.cout, bus.overflow} !== 4'b0 || bus.result !== 64'd0) begin
            errors++;
            $display("FAIL reset_mid: busy %b done %b cout %b ovf %b result %h want all 0",
                     bus.busy, bus.done, bus.cout, bus.overflow, bus.result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL reset_mid no_done: active cycles got %0d want 0", seen);
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.sub = 1'b0; bus.op_a = '0; bus.op_b = '0;
        test_reset();
        test_directed();
        test_random();
        test_start_during_run();
        test_start_held();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
